// File: rtl/sub_bytes_seq_if.sv
// ---------------------------------------------------------------------------
// sub_bytes_seq_if
// Handshake bundle for the sequential SubBytes engine.
//   in_valid  / in_ready  / in_data  : state-in channel (valid/ready)
//   out_valid / out_ready / out_data : result channel (valid/ready)
//   inv_sel                          : only with SUB_BYTES_INV_EN defined,
//                                      1 = inverse substitution
// Modports:
//   master : the side that supplies states and consumes results
//   slave  : the engine
// Optional feature macro: SUB_BYTES_INV_EN
// ---------------------------------------------------------------------------
interface sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef SUB_BYTES_INV_EN
    logic         inv_sel;

    modport master (
        output in_valid, in_data, out_ready, inv_sel,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, inv_sel,
        output in_ready, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// sub_bytes_seq
// Sequential AES SubBytes engine. A 128-bit state is loaded, then LANES
// bytes per cycle are pushed through byte S-boxes in ascending byte order
// (byte 0 = bits [7:0] first). After GROUPS = 16/LANES cycles the result is
// offered on the output channel and held until it is taken.
//
// Parameters:
//   LANES  : bytes substituted per cycle, one of 1, 2, 4, 8, 16
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : sub_bytes_seq_if.slave (in_valid/in_ready/in_data,
//            out_valid/out_ready/out_data, inv_sel when enabled)
//   busy   : high while a state is being processed or waiting to be taken
// Optional feature macro: SUB_BYTES_INV_EN adds inv_sel and InvSBox lanes;
// inv_sel is captured with the state and applies to all of its groups.
// ---------------------------------------------------------------------------

// Forward AES S-box: multiplicative inverse in GF(2^8) then affine map.
module sub_bytes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) begin
                p = p ^ s;
            end
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    logic [7:0] inv_s;

    // Substitution datapath.
    always_comb begin
        inv_s = gf_inv(a);
        y     = inv_s ^ rotl(inv_s, 1) ^ rotl(inv_s, 2) ^ rotl(inv_s, 3)
              ^ rotl(inv_s, 4) ^ 8'h63;
    end
endmodule

`ifdef SUB_BYTES_INV_EN
// Inverse AES S-box: inverse affine map then multiplicative inverse.
module sub_bytes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) begin
                p = p ^ s;
            end
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    logic [7:0] aff_s;

    // Substitution datapath.
    always_comb begin
        aff_s = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
        y     = gf_inv(aff_s);
    end
endmodule
`endif

module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sub_bytes_seq_if.slave  bus,
    output logic            busy
);
    localparam int GROUPS = 16 / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(GROUPS - 1);

    generate
        if (!((LANES == 1) || (LANES == 2) || (LANES == 4) ||
              (LANES == 8) || (LANES == 16))) begin : g_lanes_illegal
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [127:0]   data_r;
    logic [127:0]   data_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;
    logic [7:0]     lane_in_s  [LANES];
    logic [7:0]     lane_res_s [LANES];
`ifdef SUB_BYTES_INV_EN
    logic           inv_r;
    logic           inv_s;
`endif

    // Handshake and status flags decode straight from the state register.
    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = (state_r == ST_DONE);
    assign busy          = (state_r == ST_RUN) || (state_r == ST_DONE);
    assign bus.out_data  = data_r;

    // One S-box (and optionally one InvSBox) per lane, fed from the current group.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [7:0] fwd_s;

            assign lane_in_s[l] = data_r[(int'(cnt_r) * LANES + l) * 8 +: 8];

            sub_bytes_sbox u_sbox (
                .a (lane_in_s[l]),
                .y (fwd_s)
            );

`ifdef SUB_BYTES_INV_EN
            logic [7:0] rev_s;

            sub_bytes_inv_sbox u_inv_sbox (
                .a (lane_in_s[l]),
                .y (rev_s)
            );

            assign lane_res_s[l] = inv_r ? rev_s : fwd_s;
`else
            assign lane_res_s[l] = fwd_s;
`endif
        end
    endgenerate

    // Next-state logic: load on accept, substitute one group per RUN cycle.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
`ifdef SUB_BYTES_INV_EN
        inv_s   = inv_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_s = ST_RUN;
                    data_s  = bus.in_data;
                    cnt_s   = {CW{1'b0}};
`ifdef SUB_BYTES_INV_EN
                    inv_s   = bus.inv_sel;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    data_s[(int'(cnt_r) * LANES + l) * 8 +: 8] = lane_res_s[l];
                end
                if (cnt_r == LAST_GRP) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_DONE;
                end else begin
                    cnt_s   = cnt_r + 1'b1;
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // No acceptance here: a new state waits for the following IDLE cycle.
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, data and group-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            data_r  <= 128'h0;
            cnt_r   <= {CW{1'b0}};
`ifdef SUB_BYTES_INV_EN
            inv_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
`ifdef SUB_BYTES_INV_EN
            inv_r   <= inv_s;
`endif
        end
    end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_seq
// Directed bench for sub_bytes_seq. Main instance uses LANES=4; two more
// instances (LANES=1 and LANES=16) share one stimulus set for the latency
// comparison. Optional inverse test runs when SUB_BYTES_INV_EN is defined.
// ---------------------------------------------------------------------------
module tb_sub_bytes_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic busy4;
    logic busy1;
    logic busy16;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

    sub_bytes_seq_if bus4 ();
    sub_bytes_seq_if bus1 ();
    sub_bytes_seq_if bus16 ();

    sub_bytes_seq #(.LANES(4)) dut4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4.slave), .busy (busy4)
    );
    sub_bytes_seq #(.LANES(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1.slave), .busy (busy1)
    );
    sub_bytes_seq #(.LANES(16)) dut16 (
        .clk (clk), .rst_n (rst_n), .bus (bus16.slave), .busy (busy16)
    );

    always #5 clk = ~clk;

    // Offer d to the LANES=4 instance, return edges from accept to out_valid.
    task automatic accept4(input logic [127:0] d, output int lat);
        @(negedge clk);
        bus4.in_data  = d;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (bus4.out_valid !== 1'b0 || busy4 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: out_valid=%b busy=%b required 0 0", bus4.out_valid, busy4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus4.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus4.in_ready);
        end
        n_checks++;
        if (bus4.out_data !== 128'h0) begin
            n_errors++;
            $display("FAIL reset_out_data: got %h required 0", bus4.out_data);
        end
    endtask

    task automatic test_vector(input logic [127:0] din, input logic [127:0] dexp);
        int lat;
        accept4(din, lat);
        n_checks++;
        if (lat !== 4) begin
            n_errors++;
            $display("FAIL latency4: got %0d required 4", lat);
        end
        n_checks++;
        if (bus4.out_data !== dexp) begin
            n_errors++;
            $display("FAIL data4: got %h required %h", bus4.out_data, dexp);
        end
        n_checks++;
        if (busy4 !== 1'b1 || bus4.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL done_flags: busy=%b in_ready=%b required 1 0", busy4, bus4.in_ready);
        end
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        n_checks++;
        if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || busy4 !== 1'b0) begin
            n_errors++;
            $display("FAIL release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     bus4.out_valid, bus4.in_ready, busy4);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        accept4(FIPS_IN, lat);
        // Offer a different state while DONE: it must not be accepted.
        bus4.in_data  = {16{8'hff}};
        bus4.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_data !== FIPS_OUT || bus4.in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b data=%h required 1 0 %h",
                         c, bus4.out_valid, bus4.in_ready, bus4.out_data, FIPS_OUT);
            end
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        n_checks++;
        if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1",
                     bus4.out_valid, bus4.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] items [4];
        logic [127:0] exps  [4];
        int acc [4];
        int idx = 0;
        int ridx = 0;
        int cyc = 0;
        items[0] = {16{8'h00}}; exps[0] = {16{8'h63}};
        items[1] = {16{8'h01}}; exps[1] = {16{8'h7c}};
        items[2] = FIPS_IN;     exps[2] = FIPS_OUT;
        items[3] = {16{8'h53}}; exps[3] = {16{8'hed}};
        bus4.out_ready = 1'b1;
        while (ridx < 4 && cyc < 200) begin
            @(negedge clk);
            if (bus4.out_valid) begin
                n_checks++;
                if (bus4.out_data !== exps[ridx]) begin
                    n_errors++;
                    $display("FAIL b2b_result %0d: got %h required %h", ridx, bus4.out_data, exps[ridx]);
                end
                ridx++;
            end
            if (bus4.in_ready && idx < 4) begin
                bus4.in_data  = items[idx];
                bus4.in_valid = 1'b1;
                acc[idx] = cyc;
                idx++;
            end else if (idx >= 4) begin
                bus4.in_valid = 1'b0;
            end
            @(posedge clk);
            cyc++;
        end
        n_checks++;
        if (ridx !== 4) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d results required 4", ridx);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (acc[i+1] - acc[i] !== 6) begin
                n_errors++;
                $display("FAIL b2b_spacing %0d: got %0d cycles required 6", i, acc[i+1] - acc[i]);
            end
        end
        @(negedge clk);
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus4.out_valid !== 1'b0 || busy4 !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_extra: out_valid=%b busy=%b required 0 0", bus4.out_valid, busy4);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        bus4.in_data  = FIPS_IN;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus4.out_valid !== 1'b0 || busy4 !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_abort: out_valid=%b busy=%b required 0 0", bus4.out_valid, busy4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_data !== 128'h0) begin
            n_errors++;
            $display("FAIL midrun_after: in_ready=%b data=%h required 1 0", bus4.in_ready, bus4.out_data);
        end
        accept4({16{8'hff}}, lat);
        n_checks++;
        if (lat !== 4 || bus4.out_data !== {16{8'h16}}) begin
            n_errors++;
            $display("FAIL midrun_next: lat=%0d data=%h required 4 %h", lat, bus4.out_data, {16{8'h16}});
        end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_lanes_1_16();
        int lat1 = 0;
        int lat16 = 0;
        logic [127:0] d1 = 128'h0;
        logic [127:0] d16 = 128'h0;
        @(negedge clk);
        bus1.in_data   = FIPS_IN;
        bus16.in_data  = FIPS_IN;
        bus1.in_valid  = 1'b1;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus16.out_valid && lat16 == 0) begin
                lat16 = c;
                d16   = bus16.out_data;
            end
            if (bus1.out_valid && lat1 == 0) begin
                lat1 = c;
                d1   = bus1.out_data;
            end
        end
        n_checks++;
        if (lat16 !== 1 || d16 !== FIPS_OUT) begin
            n_errors++;
            $display("FAIL lanes16: lat=%0d data=%h required 1 %h", lat16, d16, FIPS_OUT);
        end
        n_checks++;
        if (lat1 !== 16 || d1 !== FIPS_OUT) begin
            n_errors++;
            $display("FAIL lanes1: lat=%0d data=%h required 16 %h", lat1, d1, FIPS_OUT);
        end
        n_checks++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== FIPS_OUT) begin
            n_errors++;
            $display("FAIL lanes16_hold: out_valid=%b data=%h required 1 %h",
                     bus16.out_valid, bus16.out_data, FIPS_OUT);
        end
        bus1.out_ready  = 1'b1;
        bus16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.out_ready  = 1'b0;
        bus16.out_ready = 1'b0;
        n_checks++;
        if (bus1.in_ready !== 1'b1 || bus16.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL lanes_release: in_ready1=%b in_ready16=%b required 1 1",
                     bus1.in_ready, bus16.in_ready);
        end
    endtask

`ifdef SUB_BYTES_INV_EN
    task automatic test_inverse();
        int lat = 0;
        @(negedge clk);
        bus4.in_data  = {16{8'h63}};
        bus4.inv_sel  = 1'b1;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.inv_sel  = 1'b0;
        while (!bus4.out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            bus4.inv_sel = ~bus4.inv_sel;
        end
        n_checks++;
        if (lat !== 4 || bus4.out_data !== 128'h0) begin
            n_errors++;
            $display("FAIL inverse: lat=%0d data=%h required 4 0", lat, bus4.out_data);
        end
        bus4.inv_sel   = 1'b0;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
    endtask
`endif

    initial begin
        bus4.in_valid   = 1'b0;
        bus4.in_data    = 128'h0;
        bus4.out_ready  = 1'b0;
        bus1.in_valid   = 1'b0;
        bus1.in_data    = 128'h0;
        bus1.out_ready  = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.in_data   = 128'h0;
        bus16.out_ready = 1'b0;
`ifdef SUB_BYTES_INV_EN
        bus4.inv_sel    = 1'b0;
        bus1.inv_sel    = 1'b0;
        bus16.inv_sel   = 1'b0;
`endif
        test_reset();
        test_vector(128'h0, {16{8'h63}});
        test_vector(FIPS_IN, FIPS_OUT);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_lanes_1_16();
`ifdef SUB_BYTES_INV_EN
        test_inverse();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
Sequential forward AES SubBytes engine: substitutes all 16 bytes of a 128-bit state using LANES byte S-boxes per cycle instead of 16. It is the forward-direction counterpart of the inverse byte-substitution stage and is intended for area-reduced encryption round datapaths. Valid/ready handshake on both sides; one state in flight at a time.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (others illegal, elaboration error)
GROUPS, 16/LANES (localparam), cycles spent in RUN per state

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid
in_ready  output  1  engine can accept a state
in_data  input  128  state to substitute; byte k = bits [8k+7:8k]
out_valid  output  1  out_data holds a finished result
out_ready  input  1  downstream accepts result
out_data  output  128  substituted state, same byte mapping
busy  output  1  high in RUN or DONE
inv_sel  input  1  only present with SUB_BYTES_INV_EN; 1 = inverse substitution

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, state register=0, group counter=0, out_valid=0, busy=0, in_ready=1 once reset released.
- FSM states: IDLE, RUN, DONE. Registered state; in_ready, out_valid, busy decoded from FSM state (no combinational in->out paths).
- IDLE: in_ready=1. in_valid&&in_ready at an edge: load in_data into state register, counter=0, go RUN. in_data ignored otherwise.
- RUN: in_ready=0. Each edge replaces bytes [counter*LANES .. counter*LANES+LANES-1] with SBox(byte) via LANES instances of the existing combinational 8-bit SBox module; counter increments. On the edge that processes group GROUPS-1: counter->0, go DONE.
- Byte order: ascending from byte 0 (bits [7:0]). Untouched bytes held.
- DONE: out_valid=1, out_data=state register, held stable while out_ready=0 (any number of cycles). out_valid&&out_ready at an edge: go IDLE; out_valid drops next cycle.
- Latency: input accepted at edge 0 -> out_valid high after edge GROUPS (LANES=4: 4 cycles; LANES=16: 1 cycle). Throughput: one state per GROUPS+2 cycles minimum.
- No acceptance in DONE even with out_ready=1 and in_valid=1 the same cycle; new state accepted earliest in the IDLE cycle that follows.
- out_data is the state register in all states; only meaningful while out_valid=1.
- counter width = max(1,clog2(GROUPS)); wrap only via explicit reset to 0 on last group.
- Reset asserted mid-RUN or mid-DONE: immediate abort, all registers to reset values, partial result discarded, no out_valid.
- in_valid changes during RUN/DONE: no effect.

Optional Feature:
SUB_BYTES_INV_EN: when defined, adds port inv_sel and LANES instances of the existing InvSBox module alongside the SBox instances; inv_sel is sampled and registered at input acceptance and selects InvSBox output for every group of that state (changing inv_sel mid-operation has no effect). When undefined: no inv_sel port, no InvSBox instances, forward substitution only.

Test Plan:
- Reset then in_data=0x00000000000000000000000000000000, LANES=4 -> out_valid high 4 cycles after accept, out_data=0x63636363636363636363636363636363.
- in_data=0x00112233445566778899aabbccddeeff -> out_data=0x638293c31bfc33f5c4eeacea4bc12816; repeat for LANES=1 (16 cycles), 16 (1 cycle), identical result.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_data/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with out_ready=1 -> states accepted every GROUPS+2 cycles, results in order, none lost or duplicated.
- rst_n pulsed low mid-RUN -> out_valid=0, in_ready=1 after release, next state 0xff..ff yields 0x16..16.
- SUB_BYTES_INV_EN defined, inv_sel=1, in_data=0x6363...63 -> out_data=0x0000...00; inv_sel toggled mid-RUN has no effect.
